soc_matrix_nios2_qsys_0_oci_dct_ctrl: RTL and testbench

Sequencer for the Nios II OCI data-capture-trace (DCT) buffer: packs 2-bit trace atoms into a 30-bit packing buffer with a 4-bit fill count. Hands completed or flushed frames to the trace sink through a one-deep frame register with valid/ready handshake. Drives the end-of-test drain so that `test_has_ended` asserts only after all captured trace has been delivered. Sits between the OCI trace source and the trace FIFO/test-bench monitor.

---
 rtl/soc_matrix_oci_dct_pkg.sv | 24 ++
 rtl/soc_matrix_oci_dct_frame_reg.sv | 43 ++++
 rtl/soc_matrix_nios2_qsys_0_oci_dct_ctrl.sv | 137 +++++++++++++
 tb/tb_soc_matrix_nios2_qsys_0_oci_dct_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_matrix_oci_dct_pkg.sv
// Shared widths, FSM state type and frame payload for the OCI DCT sequencer.
// Contents: atom/buffer/count/frame widths, idle-counter width, state_e, frame_t.
package soc_matrix_oci_dct_pkg;

  localparam int unsigned ATOM_W  = 2;
  localparam int unsigned ATOMS   = 15;
  localparam int unsigned BUF_W   = 30;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = 34;
  localparam int unsigned IDLE_W  = 10;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ENDED
  } state_e;

  // Frame payload as presented to the sink: {count, buffer}.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/soc_matrix_oci_dct_frame_reg.sv
// One-deep valid/ready holding register; a load may coincide with a pop.
// Ports: clk_i, rst_ni (async, active-low), load_i/frame_i (new frame),
//        ready_i (sink accepts), valid_o/frame_o (held frame).
module soc_matrix_oci_dct_frame_reg
  import soc_matrix_oci_dct_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   load_i,
  input  frame_t frame_i,
  input  logic   ready_i,
  output logic   valid_o,
  output frame_t frame_o
);

  logic   valid_q, valid_d;
  frame_t frame_q, frame_d;

  // Pop first, then let a load override so pop+load keeps valid high.
  always_comb begin
    valid_d = valid_q;
    frame_d = frame_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      frame_d = frame_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      frame_q <= '0;
    end else begin
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign valid_o = valid_q;
  assign frame_o = frame_q;

endmodule

// File: rtl/soc_matrix_nios2_qsys_0_oci_dct_ctrl.sv
// OCI data-capture-trace sequencer: packs 2-bit atoms LSB-first into a 30-bit
// buffer, hands full/flushed frames to a one-deep frame register, and drains
// everything before raising test_has_ended.
// Ports: clk, reset_n (async, active-low); atom_valid/atom_data/atom_ready;
//        flush_req; test_ending; dct_buffer/dct_count (live buffer);
//        frame_valid/frame_data/frame_ready (sink); test_has_ended (sticky).
// Optional: define OCI_DCT_TIMEOUT_EN to auto-flush a partial buffer after
//           TIMEOUT_CYCLES idle cycles.
module soc_matrix_nios2_qsys_0_oci_dct_ctrl
  import soc_matrix_oci_dct_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               atom_valid,
  input  logic [ATOM_W-1:0]  atom_data,
  output logic               atom_ready,
  input  logic               flush_req,
  input  logic               test_ending,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data,
  input  logic               frame_ready
  ,
  output logic               test_has_ended
);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush_q, flush_d;
  logic               ready_q, ready_d;
  logic               ended_q, ended_d;

  logic               accept_c;
  logic               free_c;
  logic               xfer_c;
  logic               timeout_c;
  frame_t             frame_q;

  // Frame register counts as free when it is being popped this cycle.
  assign accept_c = atom_valid && ready_q;
  assign free_c   = !frame_valid || frame_ready;
  assign xfer_c   = (cnt_q == CNT_W'(ATOMS) || flush_q) && (cnt_q != '0) && free_c;

`ifdef OCI_DCT_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              idle_hit_c;

  // Idle counter only runs while a partial buffer sits untouched.
  always_comb begin
    idle_hit_c = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
    timeout_c  = (cnt_q != '0) && !accept_c && !xfer_c && idle_hit_c;
    idle_d     = idle_q + IDLE_W'(1);
    if (accept_c || xfer_c || cnt_q == '0 || idle_hit_c) idle_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign timeout_c      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    ready_d = 1'b0;
    ended_d = 1'b0;

    if (xfer_c) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (accept_c) begin
      buf_d = buf_q | (BUF_W'(atom_data) << {cnt_q, 1'b0});
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A pending flush with an empty buffer simply retires.
    flush_d = (flush_q && !xfer_c && cnt_q != '0) ||
              ((state_q != ENDED) &&
               (flush_req || (state_q == RUN && test_ending) || timeout_c));

    case (state_q)
      RUN:   if (test_ending) state_d = DRAIN;
      DRAIN: if (cnt_q == '0 && !flush_q && free_c) state_d = ENDED;
      ENDED: state_d = ENDED;
      default: state_d = RUN;
    endcase

    ready_d = (state_d == RUN) && (cnt_d != CNT_W'(ATOMS)) && !flush_d;
    ended_d = (state_d == ENDED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ready_q <= 1'b0;
      ended_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      ready_q <= ready_d;
      ended_q <= ended_d;
    end
  end

  soc_matrix_oci_dct_frame_reg u_frame_reg (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .load_i  (xfer_c),
    .frame_i ('{count: cnt_q, data: buf_q}),
    .ready_i (frame_ready),
    .valid_o (frame_valid),
    .frame_o (frame_q)
  );

  assign frame_data     = frame_q;
  assign atom_ready     = ready_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_soc_matrix_nios2_qsys_0_oci_dct_ctrl.sv
// Self-checking bench for the OCI DCT sequencer: directed scenarios plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_soc_matrix_nios2_qsys_0_oci_dct_ctrl;

  localparam int TMO = 64;

  logic        clk;
  logic        reset_n;
  logic        av;
  logic [1:0]  ad;
  logic        ar;
  logic        fl;
  logic        te;
  logic [29:0] dbuf;
  logic [3:0]  dcnt;
  logic        fv;
  logic [33:0] fd;
  logic        fr;
  logic        the;

  int n_tests = 0;
  int n_fail  = 0;

  soc_matrix_nios2_qsys_0_oci_dct_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (av),
    .atom_data      (ad),
    .atom_ready     (ar),
    .flush_req      (fl),
    .test_ending    (te),
    .dct_buffer     (dbuf),
    .dct_count      (dcnt),
    .frame_valid    (fv),
    .frame_data     (fd),
    .frame_ready    (fr),
    .test_has_ended (the)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_atoms[$];   // atoms in the packing buffer, oldest first
  logic [33:0] m_fq[$];      // frame register contents (0 or 1 entries)
  bit          m_fp;         // flush pending
  bit          m_ready;      // expected atom_ready
  int          m_phase;      // 0 run, 1 drain, 2 ended
  int          m_idle;

  function automatic logic [29:0] pack_atoms();
    logic [29:0] v = '0;
    foreach (m_atoms[i]) v = v | (30'(m_atoms[i]) << (2 * i));
    return v;
  endfunction

  task automatic model_reset();
    m_atoms.delete();
    m_fq.delete();
    m_fp = 0; m_ready = 0; m_phase = 0; m_idle = 0;
  endtask

  // Advance one clock edge using the inputs currently being driven.
  task automatic model_step();
    int n;
    bit acc, busy, free, xfer, done, tmo, nfp;
    n    = m_atoms.size();
    acc  = av && m_ready;
    busy = m_fq.size() != 0;
    free = !busy || fr;
    xfer = (n == 15 || m_fp) && n != 0 && free;
    done = (m_phase == 1) && n == 0 && !m_fp && free;
    tmo  = 0;
`ifdef OCI_DCT_TIMEOUT_EN
    if (n != 0 && !acc && !xfer && m_idle == TMO - 1) tmo = 1;
    m_idle = (acc || xfer || n == 0 || m_idle == TMO - 1) ? 0 : m_idle + 1;
`endif
    if (busy && fr) void'(m_fq.pop_front());
    if (xfer) begin
      m_fq.push_back({4'(n), pack_atoms()});
      m_atoms.delete();
    end else if (acc) begin
      m_atoms.push_back(int'(ad));
    end
    nfp = (m_phase != 2 && (fl || (m_phase == 0 && te) || tmo)) ||
          (m_fp && !xfer && n != 0);
    if (m_phase == 0 && te) m_phase = 1;
    else if (done)          m_phase = 2;
    m_fp    = nfp;
    m_ready = (m_phase == 0) && (m_atoms.size() != 15) && !m_fp;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("dct_count",      64'(dcnt), 64'(m_atoms.size()));
    chk("dct_buffer",     64'(dbuf), 64'(pack_atoms()));
    chk("frame_valid",    64'(fv),   64'(m_fq.size() != 0));
    if (m_fq.size() != 0) chk("frame_data", 64'(fd), 64'(m_fq[0]));
    chk("atom_ready",     64'(ar),   64'(m_ready));
    chk("test_has_ended", 64'(the),  64'(m_phase == 2));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int seq_b[3] = '{2, 1, 3};
  logic [33:0] lit;

  initial begin
    bit hit;
    reset_n = 0; av = 0; ad = 0; fl = 0; te = 0; fr = 0;
    model_reset();

    // Reset values.
    #22;
    compare_all();
    chk("rst_frame_data", 64'(fd), 64'd0);
    #5 reset_n = 1;
    cyc();
    chk("ready_after_reset", 64'(ar), 64'd1);

    // 15 atoms of 01 with an always-ready sink.
    fr = 1;
    for (int i = 0; i < 15; i++) begin av = 1; ad = 2'b01; cyc(); end
    av = 0;
    chk("full_ready_low", 64'(ar), 64'd0);
    cyc();
    lit = 34'h3_D555_5555;
    chk("full_frame_model", 64'(m_fq.size() != 0 ? m_fq[0] : 34'd0), 64'(lit));
    chk("full_frame_dut",   64'(fd), 64'(lit));
    chk("full_count_zero",  64'(dcnt), 64'd0);
    cyc();

    // Atoms {2,1,3} then flush.
    for (int i = 0; i < 3; i++) begin av = 1; ad = 2'(seq_b[i]); cyc(); end
    av = 0; fl = 1; cyc();
    fl = 0; cyc();
    lit = 34'h0_C000_0036;
    chk("flush_frame_model", 64'(m_fq.size() != 0 ? m_fq[0] : 34'd0), 64'(lit));
    chk("flush_frame_dut",   64'(fd), 64'(lit));
    cyc();

    // Flush with an empty buffer emits nothing.
    fl = 1; cyc();
    fl = 0;
    for (int i = 0; i < 4; i++) begin cyc(); chk("empty_flush_no_frame", 64'(fv), 64'd0); end

    // Stalled sink: first frame held, second buffer fills, then back-to-back.
    fr = 0; av = 1;
    for (int i = 0; i < 40; i++) begin ad = 2'($urandom); cyc(); end
    chk("stall_count", 64'(dcnt), 64'd15);
    chk("stall_valid", 64'(fv),   64'd1);
    chk("stall_ready", 64'(ar),   64'd0);
    fr = 1; cyc();
    chk("b2b_valid", 64'(fv), 64'd1);
    av = 0;
    for (int i = 0; i < 5; i++) cyc();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      av = ($urandom_range(0, 3) != 0);
      ad = 2'($urandom);
      fr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      cyc();
    end

    // Empty everything, then build count=7 with a frame pending and reset.
    av = 0; fl = 1; fr = 1; cyc();
    fl = 0;
    for (int i = 0; i < 4; i++) cyc();
    fr = 0; av = 1; hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      ad = 2'($urandom);
      cyc();
      hit = (m_fq.size() != 0) && (m_atoms.size() == 7);
    end
    chk("mid_reset_setup", 64'(hit), 64'd1);
    av = 0;
    #1 reset_n = 0;
    #1 model_reset();
    compare_all();
    chk("async_reset_valid", 64'(fv),   64'd0);
    chk("async_reset_count", 64'(dcnt), 64'd0);
    #2 reset_n = 1;
    cyc();
    chk("ready_after_mid_reset", 64'(ar), 64'd1);
    for (int i = 0; i < 5; i++) begin fr = 1; cyc(); end

    // End-of-test drain with a delayed sink.
    fr = 0;
    for (int i = 0; i < 5; i++) begin av = 1; ad = 2'($urandom); cyc(); end
    av = 0; te = 1; cyc();
    te = 0;
    chk("drain_ready_low", 64'(ar), 64'd0);
    av = 1;
    cyc();
    chk("drain_frame_count", 64'(fd[33:30]), 64'd5);
    for (int i = 0; i < 10; i++) begin ad = 2'($urandom); cyc(); end
    chk("not_ended_yet", 64'(the), 64'd0);
    fr = 1; hit = 0;
    for (int i = 0; i < 5 && !hit; i++) begin cyc(); hit = the; end
    chk("ended_after_pop", 64'(hit), 64'd1);
    for (int i = 0; i < 30; i++) begin
      av = 1'($urandom); ad = 2'($urandom); fl = 1'($urandom);
      te = 1'($urandom); fr = 1'($urandom);
      cyc();
    end
    chk("ended_sticky", 64'(the), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
